// File: rtl/tlc_traffic_sensor_model_if.sv
// Lamp/sensor bundle between a traffic-light controller and the vehicle model.
// The controller side (master) drives lamps and arrivals. The vehicle model
// side (slave) returns the sensors, the queue state and the checker flags.
interface tlc_traffic_sensor_model_if #(
    parameter int QW = 8
);
    logic          Ga, Ya, Ra;
    logic          Gb, Yb, Rb;
    logic          arr_a, arr_b;
    logic          Sa, Sb;
    logic [QW-1:0] qa, qb;
    logic          dep_a, dep_b;
    logic          ovf_a, ovf_b;
    logic          lamp_err;
    logic [1:0]    err_code;

    modport master (
        output Ga, Ya, Ra, Gb, Yb, Rb, arr_a, arr_b,
        input  Sa, Sb, qa, qb, dep_a, dep_b, ovf_a, ovf_b, lamp_err, err_code
    );

    modport slave (
        input  Ga, Ya, Ra, Gb, Yb, Rb, arr_a, arr_b,
        output Sa, Sb, qa, qb, dep_a, dep_b, ovf_a, ovf_b, lamp_err, err_code
    );
endinterface

// File: rtl/tlc_traffic_sensor_model.sv
// Vehicle/sensor model for the far end of a two-street traffic-light controller.
// Each street keeps a saturating car queue. Arrivals add cars, and cars leave
// one every DEP_TICKS cycles while that street shows green. A lamp checker
// latches the first illegal lamp combination it sees.
module tlc_traffic_sensor_model #(
    parameter int QW        = 8,
    parameter int DEP_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    tlc_traffic_sensor_model_if.slave bus
);
    localparam int              TW       = (DEP_TICKS > 1) ? $clog2(DEP_TICKS) : 1;
    localparam logic [TW-1:0]   TMR_LAST = TW'(DEP_TICKS - 1);
    localparam logic [QW-1:0]   Q_MAX    = {QW{1'b1}};

    typedef enum logic [1:0] {
        ERR_BOTH_GREEN = 2'd0,
        ERR_CONFLICT   = 2'd1,
        ERR_A_LAMPS    = 2'd2,
        ERR_B_LAMPS    = 2'd3
    } err_e;

    logic [TW-1:0] tmr_a, tmr_b;
    logic [QW-1:0] qa, qb;
    logic          dep_a, dep_b;
    logic          ovf_a, ovf_b;
    logic          lamp_err;
    err_e          err_code;

    logic          run_a, run_b;
    logic          fire_a, fire_b;
    logic          viol;
    err_e          cause;

    // A departure timer only advances while its street is green and has a car
    // waiting. Yellow counts as stopped.
    assign run_a  = bus.Ga && (qa != '0);
    assign run_b  = bus.Gb && (qb != '0);
    assign fire_a = run_a && (tmr_a == TMR_LAST);
    assign fire_b = run_b && (tmr_b == TMR_LAST);

    // Classify the current lamp pattern and keep only the highest-priority cause.
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        viol  = 1'b1;
        cause = ERR_BOTH_GREEN;
        if (bus.Ga && bus.Gb)
            cause = ERR_BOTH_GREEN;
        else if ((bus.Ga || bus.Ya) && (bus.Gb || bus.Yb))
            cause = ERR_CONFLICT;
        else if (!$onehot({bus.Ga, bus.Ya, bus.Ra}))
            cause = ERR_A_LAMPS;
        else if (!$onehot({bus.Gb, bus.Yb, bus.Rb}))
            cause = ERR_B_LAMPS;
        else
            viol = 1'b0;
    end

    // Street A timer, queue, departure pulse and overflow flag.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_a <= '0;
            qa    <= '0;
            dep_a <= 1'b0;
            ovf_a <= 1'b0;
        end else begin
            tmr_a <= run_a ? (fire_a ? '0 : tmr_a + TW'(1)) : '0;
            dep_a <= fire_a;
            case ({bus.arr_a, fire_a})
                2'b10: begin
                    if (qa == Q_MAX) ovf_a <= 1'b1;
                    else             qa    <= qa + QW'(1);
                end
                2'b01:   qa <= qa - QW'(1);
                default: ;
            endcase
        end
    end

    // Street B timer, queue, departure pulse and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_b <= '0;
            qb    <= '0;
            dep_b <= 1'b0;
            ovf_b <= 1'b0;
        end else begin
            tmr_b <= run_b ? (fire_b ? '0 : tmr_b + TW'(1)) : '0;
            dep_b <= fire_b;
            case ({bus.arr_b, fire_b})
                2'b10: begin
                    if (qb == Q_MAX) ovf_b <= 1'b1;
                    else             qb    <= qb + QW'(1);
                end
                2'b01:   qb <= qb - QW'(1);
                default: ;
            endcase
        end
    end

    // Latch the first lamp violation and its cause. Both hold until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lamp_err <= 1'b0;
            err_code <= ERR_BOTH_GREEN;
        end else if (!lamp_err && viol) begin
            lamp_err <= 1'b1;
            err_code <= cause;
        end
    end

    assign bus.Sa       = (qa != '0);
    assign bus.Sb       = (qb != '0);
    assign bus.qa       = qa;
    assign bus.qb       = qb;
    assign bus.dep_a    = dep_a;
    assign bus.dep_b    = dep_b;
    assign bus.ovf_a    = ovf_a;
    assign bus.ovf_b    = ovf_b;
    assign bus.lamp_err = lamp_err;
    assign bus.err_code = err_code;
endmodule

// File: tb/tb_tlc_traffic_sensor_model.sv
// Bench for tlc_traffic_sensor_model. Two instances (QW=8 and QW=3,
// DEP_TICKS=4) share one stimulus stream. A behavioural model computes every
// output from the street rules, and the outputs are compared on every falling
// edge. Directed scenarios add literal expectations, and a random phase follows.
module tb_tlc_traffic_sensor_model;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       arr_a, arr_b;
    logic [2:0] la, lb;   // {G, Y, R}

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tlc_traffic_sensor_model_if #(.QW(8)) bus8();
    tlc_traffic_sensor_model_if #(.QW(3)) bus3();

    assign bus8.Ga = la[2];  assign bus8.Ya = la[1];  assign bus8.Ra = la[0];
    assign bus8.Gb = lb[2];  assign bus8.Yb = lb[1];  assign bus8.Rb = lb[0];
    assign bus8.arr_a = arr_a;  assign bus8.arr_b = arr_b;
    assign bus3.Ga = la[2];  assign bus3.Ya = la[1];  assign bus3.Ra = la[0];
    assign bus3.Gb = lb[2];  assign bus3.Yb = lb[1];  assign bus3.Rb = lb[0];
    assign bus3.arr_a = arr_a;  assign bus3.arr_b = arr_b;

    tlc_traffic_sensor_model #(.QW(8), .DEP_TICKS(DEP)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    tlc_traffic_sensor_model #(.QW(3), .DEP_TICKS(DEP)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // ---------------- behavioural model ----------------
    // Index [d][s]: d = instance (0: QW=8, 1: QW=3), s = street (0: A, 1: B).
    int mq   [2][2];
    int mrun [2][2];   // consecutive green cycles with cars waiting
    bit mdep [2][2];
    bit movf [2][2];
    bit merr [2];
    int mcode[2];
    int qmax [2] = '{255, 7};

    always @(posedge clk) begin
        bit g[2], yl[2], rd[2], ar[2];
        int na, nb, code;
        bit dep;
        g[0] = la[2];  yl[0] = la[1];  rd[0] = la[0];  ar[0] = arr_a;
        g[1] = lb[2];  yl[1] = lb[1];  rd[1] = lb[0];  ar[1] = arr_b;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int s = 0; s < 2; s++) begin
                    mq[d][s] = 0;  mrun[d][s] = 0;  mdep[d][s] = 0;  movf[d][s] = 0;
                end
                merr[d]  = 0;
                mcode[d] = 0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    dep = 0;
                    if (g[s] && mq[d][s] > 0) begin
                        mrun[d][s]++;
                        if (mrun[d][s] == DEP) begin
                            dep = 1;
                            mrun[d][s] = 0;
                        end
                    end else begin
                        mrun[d][s] = 0;
                    end
                    mdep[d][s] = dep;
                    if (ar[s] && !dep) begin
                        if (mq[d][s] == qmax[d]) movf[d][s] = 1;
                        else                     mq[d][s]++;
                    end else if (dep && !ar[s]) begin
                        mq[d][s]--;
                    end
                end
                na = int'(g[0]) + int'(yl[0]) + int'(rd[0]);
                nb = int'(g[1]) + int'(yl[1]) + int'(rd[1]);
                if (g[0] && g[1])                         code = 0;
                else if ((g[0] || yl[0]) && (g[1] || yl[1])) code = 1;
                else if (na != 1)                         code = 2;
                else if (nb != 1)                         code = 3;
                else                                      code = -1;
                if (!merr[d] && code >= 0) begin
                    merr[d]  = 1;
                    mcode[d] = code;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [7:0] qa, input logic [7:0] qb,
                           input logic sa, input logic sb, input logic da, input logic db,
                           input logic oa, input logic ob, input logic le, input logic [1:0] ec);
        string p;
        p = (d == 0) ? "q8" : "q3";
        check({p, ".qa"},       32'(qa), 32'(mq[d][0]));
        check({p, ".qb"},       32'(qb), 32'(mq[d][1]));
        check({p, ".Sa"},       32'(sa), 32'(mq[d][0] != 0));
        check({p, ".Sb"},       32'(sb), 32'(mq[d][1] != 0));
        check({p, ".dep_a"},    32'(da), 32'(mdep[d][0]));
        check({p, ".dep_b"},    32'(db), 32'(mdep[d][1]));
        check({p, ".ovf_a"},    32'(oa), 32'(movf[d][0]));
        check({p, ".ovf_b"},    32'(ob), 32'(movf[d][1]));
        check({p, ".lamp_err"}, 32'(le), 32'(merr[d]));
        check({p, ".err_code"}, 32'(ec), 32'(mcode[d]));
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        cmp_dut(0, bus8.qa, bus8.qb, bus8.Sa, bus8.Sb, bus8.dep_a, bus8.dep_b,
                bus8.ovf_a, bus8.ovf_b, bus8.lamp_err, bus8.err_code);
        cmp_dut(1, 8'(bus3.qa), 8'(bus3.qb), bus3.Sa, bus3.Sb, bus3.dep_a, bus3.dep_b,
                bus3.ovf_a, bus3.ovf_b, bus3.lamp_err, bus3.err_code);
    end

    // ---------------- stimulus ----------------
    localparam logic [2:0] L_G = 3'b100, L_Y = 3'b010, L_R = 3'b001;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] phase_a [4] = '{L_G, L_Y, L_R, L_R};
        logic [2:0] phase_b [4] = '{L_R, L_R, L_G, L_Y};
        int ph;

        reset = 1'b1;  arr_a = 1'b1;  arr_b = 1'b0;  la = L_G;  lb = L_R;

        // Reset held two cycles with arrivals and green present.
        tick(2);
        check("rst_qa", 32'(bus8.qa), 0);
        check("rst_Sa", 32'(bus8.Sa), 0);
        check("rst_lamp_err", 32'(bus8.lamp_err), 0);
        check("rst_dep_a", 32'(bus8.dep_a), 0);
        reset = 1'b0;
        tick(1);
        arr_a = 1'b0;
        check("post_rst_qa", 32'(bus8.qa), 1);
        check("post_rst_Sa", 32'(bus8.Sa), 1);

        // Queue three cars on red, then drain them on green.
        la = L_R;  lb = L_G;
        do_reset();
        arr_a = 1'b1;
        tick(3);
        arr_a = 1'b0;
        check("red_qa", 32'(bus8.qa), 3);
        check("red_dep_a", 32'(bus8.dep_a), 0);
        la = L_G;  lb = L_R;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            check("drain_dep_a", 32'(bus8.dep_a), 32'(i % 4 == 0));
            check("drain_qa", 32'(bus8.qa), 32'(3 - i / 4));
        end
        check("drain_Sa", 32'(bus8.Sa), 0);

        // Green withdrawn mid-count discards the partial count.
        la = L_R;  lb = L_G;
        do_reset();
        arr_a = 1'b1;
        tick(2);
        arr_a = 1'b0;
        la = L_G;  lb = L_R;
        tick(3);
        check("partial_qa", 32'(bus8.qa), 2);
        la = L_Y;
        tick(2);
        check("yellow_qa", 32'(bus8.qa), 2);
        check("yellow_dep_a", 32'(bus8.dep_a), 0);
        la = L_G;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("regreen_dep_a", 32'(bus8.dep_a), 32'(i == 4));
        end

        // Arrival and departure on the same edge.
        la = L_R;  lb = L_G;
        do_reset();
        arr_a = 1'b1;
        tick(1);
        arr_a = 1'b0;
        la = L_G;  lb = L_R;
        tick(3);
        arr_a = 1'b1;
        tick(1);
        arr_a = 1'b0;
        check("both_dep_a", 32'(bus8.dep_a), 1);
        check("both_qa", 32'(bus8.qa), 1);

        // Overflow on the 3-bit instance.
        la = L_G;  lb = L_R;
        do_reset();
        arr_b = 1'b1;
        tick(8);
        arr_b = 1'b0;
        check("ovf_qb3", 32'(bus3.qb), 7);
        check("ovf_flag3", 32'(bus3.ovf_b), 1);
        check("ovf_a3", 32'(bus3.ovf_a), 0);
        check("ovf_qb8", 32'(bus8.qb), 8);
        check("ovf_flag8", 32'(bus8.ovf_b), 0);
        la = L_R;  lb = L_G;
        tick(3);
        arr_b = 1'b1;
        tick(1);
        arr_b = 1'b0;
        check("full_both_dep_b", 32'(bus3.dep_b), 1);
        check("full_both_qb", 32'(bus3.qb), 7);
        tick(1);
        check("ovf_sticky", 32'(bus3.ovf_b), 1);
        do_reset();
        check("ovf_cleared", 32'(bus3.ovf_b), 0);

        // Lamp checker priorities.
        la = L_G;  lb = L_G;
        do_reset();
        tick(1);
        check("gg_err", 32'(bus8.lamp_err), 1);
        check("gg_code", 32'(bus8.err_code), 0);
        la = 3'b110;  lb = L_R;
        tick(1);
        check("gg_code_held", 32'(bus8.err_code), 0);
        la = L_Y;  lb = L_G;
        do_reset();
        tick(1);
        check("yg_code", 32'(bus8.err_code), 1);
        la = 3'b000;  lb = L_R;
        do_reset();
        tick(1);
        check("dark_a_code", 32'(bus8.err_code), 2);
        la = L_R;  lb = 3'b011;
        do_reset();
        tick(1);
        check("bad_b_code", 32'(bus8.err_code), 3);

        // Random traffic: mostly legal phases, occasional bad lamps and resets.
        la = L_G;  lb = L_R;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            arr_a = ($urandom_range(0, 2) == 0);
            arr_b = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 15) == 0) begin
                    la = 3'($urandom);
                    lb = 3'($urandom);
                end else begin
                    ph = $urandom_range(0, 3);
                    la = phase_a[ph];
                    lb = phase_b[ph];
                end
            end
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
